// File: rtl/nand_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : nand_response_checker
// Description : Response checker for NAND2..NAND5 devices. Takes each applied
//               vector through a valid/ready handshake, waits a settle
//               interval, samples the DUV output, compares it against the
//               NAND of the vector and keeps pass/fail counts, the first
//               failing vector and exhaustive-coverage status.
// Revision    : 1.0 - initial release
// ============================================================================
module nand_response_checker #(
    parameter int N_INPUTS      = 5,
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 8,
    parameter int STOP_ON_FAIL  = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                vec_valid,
    output logic                vec_ready,
    input  logic [N_INPUTS-1:0] vec,
    input  logic                duv_o,
    output logic [CNT_W-1:0]    pass_cnt,
    output logic [CNT_W-1:0]    fail_cnt,
    output logic                first_fail_valid,
    output logic [N_INPUTS-1:0] first_fail_vec,
    output logic                coverage_done,
    output logic                busy,
    output logic                done
);

    localparam int                 c_num_vec  = 1 << N_INPUTS;
    localparam int                 c_set_w    = $clog2(SETTLE_CYCLES + 1);
    localparam logic [c_set_w-1:0] c_set_load = c_set_w'(SETTLE_CYCLES);
    localparam logic [c_set_w-1:0] c_set_one  = c_set_w'(1);
    localparam logic [CNT_W-1:0]   c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]   c_cnt_one  = CNT_W'(1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_armed  = 3'd1;
    localparam logic [2:0] c_st_settle = 3'd2;
    localparam logic [2:0] c_st_check  = 3'd3;
    localparam logic [2:0] c_st_done   = 3'd4;

    logic [2:0]           r_state;
    logic [c_set_w-1:0]   r_settle;
    logic [N_INPUTS-1:0]  r_vec;
    logic                 r_sample;
    logic [c_num_vec-1:0] r_bitmap;
    logic [CNT_W-1:0]     r_pass_cnt;
    logic [CNT_W-1:0]     r_fail_cnt;
    logic                 r_ff_valid;
    logic [N_INPUTS-1:0]  r_ff_vec;
    logic                 r_cov_done;

    logic                 w_clear;
    logic                 w_check;
    logic                 w_expected;
    logic                 w_match;
    logic [c_num_vec-1:0] w_bitmap_next;
    logic                 w_all_covered;

    // start only has an effect while idle or finished
    assign w_clear       = start && ((r_state == c_st_idle) || (r_state == c_st_done));
    assign w_check       = (r_state == c_st_check);
    assign w_expected    = ~&r_vec;
    // An X/Z sample makes w_match unknown, which steers every decision below
    // into the mismatch branch.
    assign w_match       = (r_sample == w_expected);
    assign w_bitmap_next = r_bitmap | (c_num_vec'(1) << r_vec);
    assign w_all_covered = &w_bitmap_next;

    // Sequencing: accept a vector, count down the settle time, check for one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_settle <= '0;
            r_vec    <= '0;
            r_sample <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle, c_st_done: begin
                    if (start) r_state <= c_st_armed;
                end
                c_st_armed: begin
                    if (vec_valid) begin
                        r_vec    <= vec;
                        r_settle <= c_set_load;
                        r_state  <= c_st_settle;
                    end
                end
                c_st_settle: begin
                    r_settle <= r_settle - c_set_one;
                    if (r_settle == c_set_one) begin
                        r_sample <= duv_o;
                        r_state  <= c_st_check;
                    end
                end
                c_st_check: begin
                    if (w_all_covered)         r_state <= c_st_done;
                    else if (w_match)          r_state <= c_st_armed;
                    else if (STOP_ON_FAIL != 0) r_state <= c_st_done;
                    else                       r_state <= c_st_armed;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Results: saturating counters, first-fail capture and coverage bitmap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
            r_bitmap   <= '0;
            r_cov_done <= 1'b0;
        end else if (w_clear) begin
            r_pass_cnt <= '0;
            r_fail_cnt <= '0;
            r_ff_valid <= 1'b0;
            r_ff_vec   <= '0;
            r_bitmap   <= '0;
            r_cov_done <= 1'b0;
        end else if (w_check) begin
            r_bitmap   <= w_bitmap_next;
            r_cov_done <= w_all_covered;
            if (w_match) begin
                if (r_pass_cnt != c_cnt_max) r_pass_cnt <= r_pass_cnt + c_cnt_one;
            end else begin
                if (r_fail_cnt != c_cnt_max) r_fail_cnt <= r_fail_cnt + c_cnt_one;
                if (!r_ff_valid) begin
                    r_ff_valid <= 1'b1;
                    r_ff_vec   <= r_vec;
                end
            end
        end
    end

    assign vec_ready        = (r_state == c_st_armed);
    assign busy             = (r_state == c_st_settle) || (r_state == c_st_check);
    assign done             = (r_state == c_st_done);
    assign pass_cnt         = r_pass_cnt;
    assign fail_cnt         = r_fail_cnt;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_vec   = r_ff_vec;
    assign coverage_done    = r_cov_done;

endmodule
`default_nettype wire

// File: tb/tb_nand_response_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_nand_response_checker
// Description : Scoreboard bench for nand_response_checker. Three checker
//               instances with different parameter sets share clock and
//               reset; each is fed from a behavioural DUV model that can be
//               correct, stuck-at-1 or stuck-at-0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nand_response_checker;

    localparam int c_n_in   [3] = '{3, 2, 5};
    localparam int c_settle [3] = '{4, 2, 3};
    localparam int c_cnt_w  [3] = '{8, 8, 3};
    localparam int c_stop   [3] = '{0, 0, 1};
    localparam int c_tmo        = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start     [3];
    logic       vec_valid [3];
    logic [4:0] vec       [3];
    logic [1:0] mode      [3];   // 0 correct, 1 stuck-at-1, 2 stuck-at-0

    wire        vec_ready [3];
    wire  [7:0] pass_cnt  [3];
    wire  [7:0] fail_cnt  [3];
    wire        ff_valid  [3];
    wire  [4:0] ff_vec    [3];
    wire        cov_done  [3];
    wire        busy      [3];
    wire        done      [3];

    typedef struct {
        int         inst;
        logic [4:0] v;
        logic       pass;
    } sb_t;

    sb_t         sb_q [$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_pass  [3];
    int          exp_fail  [3];
    logic        exp_ffv   [3];
    logic [4:0]  exp_ffvec [3];
    logic [31:0] exp_map   [3];

    always #5 clk = ~clk;

    function automatic logic nand_ref(logic [4:0] v, int n);
        logic [4:0] m;
        m = 5'((1 << n) - 1);
        return ((v & m) != m);
    endfunction

    function automatic logic duv_model(logic [1:0] md, logic [4:0] v, int n);
        case (md)
            2'd1:    return 1'b1;
            2'd2:    return 1'b0;
            default: return nand_ref(v, n);
        endcase
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        wire [c_cnt_w[g]-1:0] w_pass;
        wire [c_cnt_w[g]-1:0] w_fail;
        wire [c_n_in[g]-1:0]  w_ffvec;
        wire                  w_duv;

        assign w_duv       = duv_model(mode[g], vec[g], c_n_in[g]);
        assign pass_cnt[g] = 8'(w_pass);
        assign fail_cnt[g] = 8'(w_fail);
        assign ff_vec[g]   = 5'(w_ffvec);

        nand_response_checker #(
            .N_INPUTS      (c_n_in[g]),
            .SETTLE_CYCLES (c_settle[g]),
            .CNT_W         (c_cnt_w[g]),
            .STOP_ON_FAIL  (c_stop[g])
        ) u_dut (
            .clk              (clk),
            .rst              (rst),
            .start            (start[g]),
            .vec_valid        (vec_valid[g]),
            .vec_ready        (vec_ready[g]),
            .vec              (vec[g][c_n_in[g]-1:0]),
            .duv_o            (w_duv),
            .pass_cnt         (w_pass),
            .fail_cnt         (w_fail),
            .first_fail_valid (ff_valid[g]),
            .first_fail_vec   (w_ffvec),
            .coverage_done    (cov_done[g]),
            .busy             (busy[g]),
            .done             (done[g])
        );
    end

    task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_clear(int i);
        exp_pass[i]  = 0;
        exp_fail[i]  = 0;
        exp_ffv[i]   = 1'b0;
        exp_ffvec[i] = 5'd0;
        exp_map[i]   = 32'd0;
    endtask

    task automatic do_start(int i);
        start[i] = 1'b1;
        @(posedge clk); #1;
        start[i] = 1'b0;
        model_clear(i);
        check_eq($sformatf("start_ready[%0d]", i), vec_ready[i], 1);
        check_eq($sformatf("start_pass[%0d]", i), pass_cnt[i], 0);
        check_eq($sformatf("start_fail[%0d]", i), fail_cnt[i], 0);
        check_eq($sformatf("start_ffv[%0d]", i), ff_valid[i], 0);
        check_eq($sformatf("start_cov[%0d]", i), cov_done[i], 0);
        check_eq($sformatf("start_done[%0d]", i), done[i], 0);
    endtask

    // Pop the oldest expectation, advance the reference model, compare results
    task automatic sb_pop_check();
        sb_t         e;
        int          i;
        int          maxc;
        logic [31:0] full;
        logic        exp_done;
        string       t;
        e    = sb_q.pop_front();
        i    = e.inst;
        maxc = (1 << c_cnt_w[i]) - 1;
        if (e.pass) begin
            if (exp_pass[i] < maxc) exp_pass[i]++;
        end else begin
            if (exp_fail[i] < maxc) exp_fail[i]++;
            if (!exp_ffv[i]) begin
                exp_ffv[i]   = 1'b1;
                exp_ffvec[i] = e.v;
            end
        end
        exp_map[i] = exp_map[i] | (32'd1 << e.v);
        full       = 32'((64'd1 << (1 << c_n_in[i])) - 64'd1);
        exp_done   = (exp_map[i] == full) || (!e.pass && (c_stop[i] != 0));
        t = $sformatf("[%0d] v=%0d", i, e.v);
        check_eq({"pass", t}, pass_cnt[i], exp_pass[i]);
        check_eq({"fail", t}, fail_cnt[i], exp_fail[i]);
        check_eq({"ffv", t}, ff_valid[i], exp_ffv[i]);
        check_eq({"ffvec", t}, ff_vec[i], exp_ffvec[i]);
        check_eq({"cov", t}, cov_done[i], (exp_map[i] == full));
        check_eq({"done", t}, done[i], exp_done);
    endtask

    // Offer one vector, optionally pulse start k edges after accept, wait for the check
    task automatic send_vec(int i, int v, int start_at, output int low_cnt);
        sb_t        e;
        int         k;
        logic [7:0] p0;
        logic [7:0] f0;
        logic       early;
        k = 0;
        while (vec_ready[i] !== 1'b1 && k < c_tmo) begin
            @(posedge clk); #1;
            k++;
        end
        check_eq($sformatf("ready_wait[%0d]", i), vec_ready[i], 1);
        vec[i]       = 5'(v);
        vec_valid[i] = 1'b1;
        e.inst = i;
        e.v    = 5'(v);
        e.pass = (duv_model(mode[i], 5'(v), c_n_in[i]) == nand_ref(5'(v), c_n_in[i]));
        sb_q.push_back(e);
        p0 = pass_cnt[i];
        f0 = fail_cnt[i];
        @(posedge clk); #1;
        vec_valid[i] = 1'b0;
        k       = 0;
        low_cnt = 0;
        early   = 1'b0;
        while (busy[i] === 1'b1 && k < c_tmo) begin
            if (vec_ready[i] !== 1'b1) low_cnt++;
            if (pass_cnt[i] !== p0 || fail_cnt[i] !== f0) early = 1'b1;
            start[i] = (k == start_at);
            @(posedge clk); #1;
            k++;
        end
        start[i] = 1'b0;
        check_eq($sformatf("latency[%0d] v=%0d", i, v), k, c_settle[i] + 1);
        check_eq($sformatf("early_update[%0d] v=%0d", i, v), early, 0);
        sb_pop_check();
    endtask

    initial begin
        int lc;
        for (int i = 0; i < 3; i++) begin
            start[i]     = 1'b0;
            vec_valid[i] = 1'b0;
            vec[i]       = 5'd0;
            mode[i]      = 2'd0;
            model_clear(i);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("rst_ready[%0d]", i), vec_ready[i], 0);
            check_eq($sformatf("rst_busy[%0d]", i), busy[i], 0);
            check_eq($sformatf("rst_done[%0d]", i), done[i], 0);
            check_eq($sformatf("rst_pass[%0d]", i), pass_cnt[i], 0);
            check_eq($sformatf("rst_cov[%0d]", i), cov_done[i], 0);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("idle_ready", vec_ready[0], 0);

        // NAND3, correct model, exhaustive
        do_start(0);
        for (int v = 0; v < 8; v++) send_vec(0, v, -1, lc);

        // NAND3, stuck-at-1: only vector 7 fails
        mode[0] = 2'd1;
        do_start(0);
        for (int v = 0; v < 8; v++) send_vec(0, v, -1, lc);

        // NAND2 with a duplicate vector; handshake timing
        do_start(1);
        send_vec(1, 0, -1, lc);
        check_eq("ready_low_cycles", lc, c_settle[1] + 1);
        send_vec(1, 1, -1, lc);
        send_vec(1, 1, -1, lc);
        send_vec(1, 2, -1, lc);
        send_vec(1, 3, -1, lc);

        // NAND5, stop on first fail with stuck-at-0, then restart and saturate
        mode[2] = 2'd2;
        do_start(2);
        send_vec(2, 0, -1, lc);
        mode[2] = 2'd0;
        do_start(2);
        for (int v = 0; v < 32; v++) send_vec(2, v, -1, lc);

        // start during SETTLE must not clear anything
        mode[0] = 2'd0;
        do_start(0);
        send_vec(0, 5, 1, lc);

        // reset two cycles into SETTLE
        vec[0]       = 5'd6;
        vec_valid[0] = 1'b1;
        @(posedge clk); #1;
        vec_valid[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("pre_rst_busy", busy[0], 1);
        rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("async_rst_ready[%0d]", i), vec_ready[i], 0);
            check_eq($sformatf("async_rst_busy[%0d]", i), busy[i], 0);
            check_eq($sformatf("async_rst_done[%0d]", i), done[i], 0);
            check_eq($sformatf("async_rst_pass[%0d]", i), pass_cnt[i], 0);
            check_eq($sformatf("async_rst_cov[%0d]", i), cov_done[i], 0);
            check_eq($sformatf("async_rst_ffv[%0d]", i), ff_valid[i], 0);
            model_clear(i);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("post_rst_ready", vec_ready[0], 0);
            check_eq("post_rst_busy", busy[0], 0);
        end
        do_start(0);
        send_vec(0, 6, -1, lc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
